// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory/writeback stage (master) and the
// data memory (slave). Signal names keep the stage-side I_/O_ prefixes.
interface mem_stage_if;
  logic [15:0] O_mem_addr;
  logic [15:0] O_mem_wdata;
  logic        O_mem_req;
  logic        O_mem_we;
  logic        I_mem_ack;
  logic [15:0] I_mem_rdata;

  modport master (
    output O_mem_addr, O_mem_wdata, O_mem_req, O_mem_we,
    input  I_mem_ack, I_mem_rdata
  );

  modport slave (
    input  O_mem_addr, O_mem_wdata, O_mem_req, O_mem_we,
    output I_mem_ack, I_mem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access / writeback stage behind the ALU. Non-memory results are
// written back one cycle after acceptance; READ/WRITE results run a req/ack
// bus transaction first, bounded by TIMEOUT cycles. A timeout parks the
// stage in a sticky ERROR state until reset.
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_enable,
  input  logic [15:0] I_alu_out,
  input  logic        I_write_rD,
  input  logic        I_write_pc,
  input  logic [1:0]  I_memory_mode,
  input  logic [15:0] I_store_data,
  input  logic [2:0]  I_rD_sel,
  mem_stage_if.master mem,
  output logic [15:0] O_rD_data,
  output logic [2:0]  O_rD_sel,
  output logic        O_rD_write,
  output logic [15:0] O_pc,
  output logic        O_pc_write,
  output logic        O_done,
  output logic        O_busy,
  output logic        O_error
);

  localparam logic [1:0] MEM_NOP   = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  // Last cycle in which a missing ack is still tolerated.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ERROR
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wr_rd_q;
  logic [2:0]       sel_q;
  logic [15:0]      addr_q;
  logic [15:0]      wdata_q;
  logic             req_q;
  logic             we_q;
  logic [15:0]      rd_data_q;
  logic [2:0]       rd_sel_q;
  logic             rd_write_q;
  logic [15:0]      pc_q;
  logic             pc_write_q;
  logic             done_q;
  logic             busy_q;
  logic             error_q;

  // Reserved mode 2'b11 behaves like MEM_NOP.
  logic is_mem_op;
  assign is_mem_op = (I_memory_mode == MEM_READ) || (I_memory_mode == MEM_WRITE);

  // Control FSM with registered outputs; strobes default low every cycle.
  always_ff @(posedge I_clk or negedge I_reset) begin
    if (!I_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wr_rd_q    <= 1'b0;
      sel_q      <= 3'd0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      rd_data_q  <= 16'h0000;
      rd_sel_q   <= 3'd0;
      rd_write_q <= 1'b0;
      pc_q       <= 16'h0000;
      pc_write_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      rd_write_q <= 1'b0;
      pc_write_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (I_enable) begin
            if (is_mem_op) begin
              req_q   <= 1'b1;
              addr_q  <= I_alu_out;
              we_q    <= (I_memory_mode == MEM_WRITE);
              wdata_q <= I_store_data;
              sel_q   <= I_rD_sel;
              wr_rd_q <= I_write_rD;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_ACCESS;
            end else begin
              done_q     <= 1'b1;
              rd_write_q <= I_write_rD;
              rd_data_q  <= I_alu_out;
              rd_sel_q   <= I_rD_sel;
              pc_write_q <= I_write_pc;
              pc_q       <= I_alu_out;
            end
          end
        end
        S_ACCESS: begin
          // An ack on the timeout cycle still completes normally.
          if (mem.I_mem_ack) begin
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
            if (!we_q) begin
              rd_data_q  <= mem.I_mem_rdata;
              rd_sel_q   <= sel_q;
              rd_write_q <= wr_rd_q;
            end
          end else if (cnt_q == CNT_LAST) begin
            req_q   <= 1'b0;
            error_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_ERROR;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_ERROR: begin
          state_q <= S_ERROR;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem.O_mem_addr  = addr_q;
  assign mem.O_mem_wdata = wdata_q;
  assign mem.O_mem_req   = req_q;
  assign mem.O_mem_we    = we_q;

  assign O_rD_data  = rd_data_q;
  assign O_rD_sel   = rd_sel_q;
  assign O_rD_write = rd_write_q;
  assign O_pc       = pc_q;
  assign O_pc_write = pc_write_q;
  assign O_done     = done_q;
  assign O_busy     = busy_q;
  assign O_error    = error_q;

endmodule
